// File: rtl/mem_arb_pkg.sv
// Shared types for the SRAM port arbiter: FSM states, owner encoding and
// the width of the consecutive-vector-grant counter.
package mem_arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_RESP} arb_state_t;
    typedef enum logic {OWN_CPU, OWN_VEC} arb_owner_t;

    localparam int VEC_RUN_W = 4;
    localparam logic [VEC_RUN_W-1:0] VEC_RUN_MAX = '1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for mem_port_arbiter.
// ARB_ROUND_ROBIN_EN selects round-robin tie-break; otherwise the vector unit wins ties.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_VEC_GRANTS = 4
) (
    input  logic                 cpu_valid,
    input  logic                 vec_valid,
    input  arb_owner_t           last,
    input  logic [VEC_RUN_W-1:0] vec_run,
    output arb_owner_t           winner
);

    logic cpu_starved;

    assign cpu_starved = (vec_run >= VEC_RUN_W'(MAX_VEC_GRANTS));

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed priority ignores the history input; keep it formally consumed.
    logic unused_last;
    assign unused_last = last;
`endif

    always_comb begin
        winner = OWN_CPU;
        if (cpu_valid && vec_valid) begin
            if (cpu_starved) begin
                winner = OWN_CPU;
            end else begin
`ifdef ARB_ROUND_ROBIN_EN
                winner = (last == OWN_CPU) ? OWN_VEC : OWN_CPU;
`else
                winner = OWN_VEC;
`endif
            end
        end else if (vec_valid) begin
            winner = OWN_VEC;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port SRAM between the CPU and the vector unit, one
// IDLE -> ISSUE -> RESP transaction at a time. Option macro: ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_VEC_GRANTS = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    cpu_valid,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_wdata,
    input  logic [DATA_WIDTH/8-1:0] cpu_wstrb,
    output logic                    cpu_ready,
    output logic [DATA_WIDTH-1:0]   cpu_rdata,
    input  logic                    vec_valid,
    input  logic [ADDR_WIDTH-1:0]   vec_addr,
    input  logic [DATA_WIDTH-1:0]   vec_wdata,
    input  logic [DATA_WIDTH/8-1:0] vec_wstrb,
    output logic                    vec_ready,
    output logic [DATA_WIDTH-1:0]   vec_rdata,
    output logic                    sram_en,
    output logic [DATA_WIDTH/8-1:0] sram_wstrb,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    output logic [DATA_WIDTH-1:0]   sram_wdata,
    input  logic [DATA_WIDTH-1:0]   sram_rdata,
    output logic                    busy
);

    arb_state_t           state_q, state_d;
    arb_owner_t           owner_q, owner_d;
    arb_owner_t           winner, last_sel;
    logic [VEC_RUN_W-1:0] vec_run_q, vec_run_d;
    logic                 grant;

    // Requests are only sampled in IDLE, so one dropped while in flight is never re-granted.
    assign grant = (state_q == ARB_IDLE) && (cpu_valid || vec_valid);

`ifdef ARB_ROUND_ROBIN_EN
    arb_owner_t last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (grant) begin
            last_d = winner;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_q <= OWN_CPU;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_sel = last_q;
`else
    assign last_sel = OWN_CPU;
`endif

    mem_arb_pick #(
        .MAX_VEC_GRANTS(MAX_VEC_GRANTS)
    ) u_pick (
        .cpu_valid(cpu_valid),
        .vec_valid(vec_valid),
        .last     (last_sel),
        .vec_run  (vec_run_q),
        .winner   (winner)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first so no path infers a latch.
        state_d    = state_q;
        owner_d    = owner_q;
        vec_run_d  = vec_run_q;
        busy       = (state_q != ARB_IDLE);
        sram_en    = 1'b0;
        sram_wstrb = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        cpu_ready  = 1'b0;
        cpu_rdata  = '0;
        vec_ready  = 1'b0;
        vec_rdata  = '0;

        case (state_q)
            ARB_IDLE: begin
                if (grant) begin
                    state_d = ARB_ISSUE;
                    owner_d = winner;
                    if (winner == OWN_VEC) begin
                        vec_run_d = (vec_run_q == VEC_RUN_MAX) ? vec_run_q
                                                               : vec_run_q + VEC_RUN_W'(1);
                    end else begin
                        vec_run_d = '0;
                    end
                end
            end
            ARB_ISSUE: begin
                state_d = ARB_RESP;
                sram_en = 1'b1;
                if (owner_q == OWN_VEC) begin
                    sram_wstrb = vec_wstrb;
                    sram_addr  = vec_addr;
                    sram_wdata = vec_wdata;
                end else begin
                    sram_wstrb = cpu_wstrb;
                    sram_addr  = cpu_addr;
                    sram_wdata = cpu_wdata;
                end
            end
            ARB_RESP: begin
                // The response is emitted even if the owner has withdrawn its request.
                state_d = ARB_IDLE;
                if (owner_q == OWN_VEC) begin
                    vec_ready = 1'b1;
                    vec_rdata = sram_rdata;
                end else begin
                    cpu_ready = 1'b1;
                    cpu_rdata = sram_rdata;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ARB_IDLE;
            owner_q   <= OWN_CPU;
            vec_run_q <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            vec_run_q <= vec_run_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model plus directed checks.
// Honours ARB_ROUND_ROBIN_EN when the bundle is built with it.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int MAXV = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          cpu_valid, vec_valid;
    logic [AW-1:0] cpu_addr, vec_addr;
    logic [DW-1:0] cpu_wdata, vec_wdata;
    logic [SW-1:0] cpu_wstrb, vec_wstrb;
    logic          cpu_ready, vec_ready;
    logic [DW-1:0] cpu_rdata, vec_rdata;
    logic          sram_en;
    logic [SW-1:0] sram_wstrb;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_wdata;
    logic [DW-1:0] sram_rdata = '0;
    logic          busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_VEC_GRANTS(MAXV)
    ) dut (
        .clk(clk), .resetn(resetn),
        .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .vec_valid(vec_valid), .vec_addr(vec_addr), .vec_wdata(vec_wdata),
        .vec_wstrb(vec_wstrb), .vec_ready(vec_ready), .vec_rdata(vec_rdata),
        .sram_en(sram_en), .sram_wstrb(sram_wstrb), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // SRAM macro: registered read (old data on a write), byte-masked write.
    logic [DW-1:0] sram_mem [256];
    always @(posedge clk) begin
        if (sram_en) begin
            sram_rdata <= sram_mem[sram_addr[9:2]];
            for (int b = 0; b < SW; b++)
                if (sram_wstrb[b]) sram_mem[sram_addr[9:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
        end
    end

    // Transaction-level model: a grant at sample cycle g implies the access at g+1,
    // the ready pulse at g+2 and a free arbiter again from g+3.
    typedef struct {
        bit            active;
        int            g;
        arb_owner_t    own;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        logic [DW-1:0] rdata;
    } txn_t;

    txn_t          cur;
    int            cyc = 0;
    int            m_vec_run = 0;
    arb_owner_t    m_last = OWN_CPU;
    arb_owner_t    w;
    logic [DW-1:0] ref_mem [256];
    arb_owner_t    grant_log [$];
    int            ready_cyc [$];
    int            sram_en_seen = 0;
    bit            cpu_seen_ready = 0, vec_seen_ready = 0;
    bit            exp_issue, exp_resp;

    always @(negedge clk) begin
        cyc++;
        if (!resetn) begin
            cur.active = 0;
            m_vec_run  = 0;
            m_last     = OWN_CPU;
        end
        exp_issue = cur.active && (cyc == cur.g + 1);
        exp_resp  = cur.active && (cyc == cur.g + 2);

        check("busy", busy, exp_issue || exp_resp);
        check("sram_en", sram_en, exp_issue);
        if (exp_issue) begin
            check("sram_addr", sram_addr, cur.addr);
            check("sram_wdata", sram_wdata, cur.wdata);
            check("sram_wstrb", sram_wstrb, cur.wstrb);
        end
        check("cpu_ready", cpu_ready, exp_resp && cur.own == OWN_CPU);
        check("vec_ready", vec_ready, exp_resp && cur.own == OWN_VEC);
        if (exp_resp) begin
            check("cpu_rdata", cpu_rdata, (cur.own == OWN_CPU) ? cur.rdata : '0);
            check("vec_rdata", vec_rdata, (cur.own == OWN_VEC) ? cur.rdata : '0);
        end
        if (!resetn) begin
            check("rst_cpu_rdata", cpu_rdata, 0);
            check("rst_vec_rdata", vec_rdata, 0);
            check("rst_sram_addr", sram_addr, 0);
            check("rst_sram_wdata", sram_wdata, 0);
            check("rst_sram_wstrb", sram_wstrb, 0);
        end

        if (cpu_ready) begin grant_log.push_back(OWN_CPU); ready_cyc.push_back(cyc); end
        if (vec_ready) begin grant_log.push_back(OWN_VEC); ready_cyc.push_back(cyc); end
        cpu_seen_ready = cpu_ready;
        vec_seen_ready = vec_ready;
        if (sram_en) sram_en_seen++;

        if (cur.active && cyc >= cur.g + 3) cur.active = 0;
        if (resetn && !cur.active && (cpu_valid || vec_valid)) begin
            if (cpu_valid && vec_valid) begin
                if (m_vec_run >= MAXV) w = OWN_CPU;
`ifdef ARB_ROUND_ROBIN_EN
                else w = (m_last == OWN_VEC) ? OWN_CPU : OWN_VEC;
`else
                else w = OWN_VEC;
`endif
            end else begin
                w = cpu_valid ? OWN_CPU : OWN_VEC;
            end
            m_vec_run = (w == OWN_VEC) ? ((m_vec_run < 15) ? m_vec_run + 1 : 15) : 0;
            m_last    = w;
            cur.active = 1;
            cur.g      = cyc;
            cur.own    = w;
            cur.addr   = (w == OWN_VEC) ? vec_addr  : cpu_addr;
            cur.wdata  = (w == OWN_VEC) ? vec_wdata : cpu_wdata;
            cur.wstrb  = (w == OWN_VEC) ? vec_wstrb : cpu_wstrb;
            cur.rdata  = ref_mem[cur.addr[9:2]];
            for (int b = 0; b < SW; b++)
                if (cur.wstrb[b]) ref_mem[cur.addr[9:2]][8*b +: 8] = cur.wdata[8*b +: 8];
        end
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } op_t;

    op_t cpu_q [$];
    op_t vec_q [$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Both requesters replay their queues, each holding valid until its ready.
    task automatic run_auto(input int budget);
        int n = 0;
        while ((cpu_q.size() > 0 || vec_q.size() > 0) && n < budget) begin
            cpu_valid = (cpu_q.size() > 0);
            if (cpu_valid) begin
                cpu_addr = cpu_q[0].addr; cpu_wdata = cpu_q[0].wdata; cpu_wstrb = cpu_q[0].wstrb;
            end
            vec_valid = (vec_q.size() > 0);
            if (vec_valid) begin
                vec_addr = vec_q[0].addr; vec_wdata = vec_q[0].wdata; vec_wstrb = vec_q[0].wstrb;
            end
            step();
            n++;
            if (cpu_valid && cpu_seen_ready) void'(cpu_q.pop_front());
            if (vec_valid && vec_seen_ready) void'(vec_q.pop_front());
        end
        cpu_valid = 0;
        vec_valid = 0;
        check("auto_drain", cpu_q.size() + vec_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    arb_owner_t exp_order [10];
    int         sram_cnt0;

    initial begin
        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = 32'hA500_0000 | i;
            ref_mem[i]  = 32'hA500_0000 | i;
        end
        sram_mem[64] = 32'hDEAD_BEEF;
        ref_mem[64]  = 32'hDEAD_BEEF;

        resetn = 0;
        cpu_valid = 0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
        vec_valid = 0; vec_addr = '0; vec_wdata = '0; vec_wstrb = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_sram_en", sram_en, 0);
        check("rst_ready", {cpu_ready, vec_ready}, 0);
        step();
        resetn = 1;
        step();

        // 1: CPU read alone
        cpu_valid = 1; cpu_addr = 32'h100; cpu_wstrb = '0; cpu_wdata = '0;
        @(negedge clk);
        check("t1_n_busy", busy, 0);
        @(negedge clk);
        check("t1_n1_sram_en", sram_en, 1);
        check("t1_n1_sram_addr", sram_addr, 32'h100);
        check("t1_n1_sram_wstrb", sram_wstrb, 0);
        @(negedge clk);
        check("t1_n2_cpu_ready", cpu_ready, 1);
        check("t1_n2_cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        check("t1_n2_vec_ready", vec_ready, 0);
        step();
        cpu_valid = 0;
        step();

        // 2: vector write alone, then read back
        vec_valid = 1; vec_addr = 32'h40; vec_wdata = 32'h1234_5678; vec_wstrb = 4'hF;
        @(negedge clk);
        @(negedge clk);
        check("t2_n1_sram_wstrb", sram_wstrb, 4'hF);
        check("t2_n1_sram_addr", sram_addr, 32'h40);
        check("t2_n1_sram_wdata", sram_wdata, 32'h1234_5678);
        @(negedge clk);
        check("t2_n2_vec_ready", vec_ready, 1);
        check("t2_n2_cpu_ready", cpu_ready, 0);
        step();
        vec_wstrb = '0; vec_wdata = '0;
        repeat (3) @(negedge clk);
        check("t2_rb_vec_ready", vec_ready, 1);
        check("t2_rb_vec_rdata", vec_rdata, 32'h1234_5678);
        step();
        vec_valid = 0;
        step();

        // 5: vector drops valid during ISSUE; CPU must get the next slot only
        sram_cnt0 = sram_en_seen;
        vec_valid = 1; vec_addr = 32'h80; vec_wstrb = '0;
        @(negedge clk);
        step();
        vec_valid = 0;
        cpu_valid = 1; cpu_addr = 32'h84; cpu_wstrb = '0;
        @(negedge clk);
        check("t5_vec_issue_addr", sram_addr, 32'h80);
        @(negedge clk);
        check("t5_vec_ready", vec_ready, 1);
        check("t5_vec_rdata", vec_rdata, 32'hA500_0020);
        check("t5_cpu_rdata_zero", cpu_rdata, 0);
        @(negedge clk);
        check("t5_idle_gap", busy, 0);
        @(negedge clk);
        check("t5_cpu_issue_addr", sram_addr, 32'h84);
        @(negedge clk);
        check("t5_cpu_ready", cpu_ready, 1);
        check("t5_cpu_rdata", cpu_rdata, 32'hA500_0021);
        step();
        cpu_valid = 0;
        repeat (3) @(negedge clk);
        check("t5_sram_accesses", sram_en_seen - sram_cnt0, 2);
        step();

        // 3/4: both requesters continuously valid
        for (int i = 0; i < 10; i++) begin
            cpu_q.push_back('{addr: 32'h200 + 4 * i, wdata: '0, wstrb: '0});
            vec_q.push_back('{addr: 32'h300 + 4 * i, wdata: 32'h5A00_0000 + i,
                              wstrb: 4'(i) | 4'h1});
`ifdef ARB_ROUND_ROBIN_EN
            exp_order[i] = (i % 2 == 1) ? OWN_CPU : OWN_VEC;
`else
            exp_order[i] = (i % 5 == 4) ? OWN_CPU : OWN_VEC;
`endif
        end
        grant_log.delete();
        ready_cyc.delete();
        run_auto(200);
        check("order_len", grant_log.size() >= 10, 1);
        for (int i = 0; i < 10 && i < grant_log.size(); i++)
            check($sformatf("order_%0d", i), grant_log[i], exp_order[i]);
        for (int i = 1; i < 10 && i < ready_cyc.size(); i++)
            check($sformatf("ready_gap_%0d", i), ready_cyc[i] - ready_cyc[i-1], 3);
        step();

        // 6: reset asserted during ISSUE
        cpu_valid = 1; cpu_addr = 32'h10; cpu_wstrb = '0;
        @(negedge clk);
        @(posedge clk);
        #1;
        check("t6_issue_sram_en", sram_en, 1);
        resetn = 0;
        cpu_valid = 0;
        #1;
        check("t6_rst_sram_en", sram_en, 0);
        check("t6_rst_ready", {cpu_ready, vec_ready}, 0);
        check("t6_rst_busy", busy, 0);
        repeat (2) step();
        resetn = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t6_post_busy_%0d", i), busy, 0);
        end
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
